// File: rtl/sprite_arb_pkg.sv
// Shared state type, default sizing and helpers for the sprite fetch arbiter.
// Build option: SPRITE_ARB_FIXED_PRIO_EN selects fixed-priority grant selection.
package sprite_arb_pkg;

  localparam int unsigned DefNreq = 4;
  localparam int unsigned DefAw   = 11;
  localparam int unsigned DefDw   = 16;
  localparam int unsigned DefLw   = 5;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StBurst = 1'b1
  } arb_state_e;

  // Width of a requester index; never zero so single-requester builds still elaborate.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_fetch_arbiter_if.sv
// Request, sprite RAM read-port and read-beat signals of the sprite fetch arbiter.
// Build option: SPRITE_ARB_FIXED_PRIO_EN (no effect on this interface).
interface sprite_fetch_arbiter_if
  import sprite_arb_pkg::*;
#(
  parameter int unsigned NREQ = DefNreq,
  parameter int unsigned AW   = DefAw,
  parameter int unsigned DW   = DefDw,
  parameter int unsigned LW   = DefLw
) ();

  localparam int unsigned IW = id_width(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*LW-1:0] req_len;
  logic [NREQ-1:0]    req_ready;
  logic               freeze;
  logic [AW-1:0]      mem_address;
  logic               mem_chipselect;
  logic [DW-1:0]      mem_readdata;
  logic               rd_valid;
  logic [DW-1:0]      rd_data;
  logic [IW-1:0]      rd_id;
  logic               rd_last;
  logic               busy;

  // Arbiter side.
  modport slave (
    input  req_valid, req_addr, req_len, freeze, mem_readdata,
    output req_ready, mem_address, mem_chipselect, rd_valid, rd_data, rd_id, rd_last, busy
  );

  // Requester / RAM side.
  modport master (
    output req_valid, req_addr, req_len, freeze, mem_readdata,
    input  req_ready, mem_address, mem_chipselect, rd_valid, rd_data, rd_id, rd_last, busy
  );

endinterface

// File: rtl/sprite_rr_arbiter.sv
// Combinational one-hot grant selection for the sprite fetch arbiter.
// Build option: SPRITE_ARB_FIXED_PRIO_EN -> lowest active index wins and no pointer
// input exists; otherwise the search starts at ptr_i and wraps.
module sprite_rr_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int unsigned NREQ = DefNreq,
  parameter int unsigned IW   = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
`ifndef SPRITE_ARB_FIXED_PRIO_EN
  input  logic [IW-1:0]   ptr_i,
`endif
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   gnt_idx_o
);

  logic          found;
  logic [IW-1:0] idx;

  // First active requester in search order wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
`ifdef SPRITE_ARB_FIXED_PRIO_EN
      idx = IW'(i);
`else
      idx = IW'((32'(ptr_i) + i) % NREQ);
`endif
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/sprite_fetch_arbiter.sv
// Sprite fetch arbiter: grants one requester at a time and streams its burst of
// sprite RAM words, one address per unfrozen cycle, with beats returned a cycle later.
// Build option: SPRITE_ARB_FIXED_PRIO_EN -> fixed-priority grant, no round-robin pointer.
module sprite_fetch_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int unsigned NREQ = DefNreq,
  parameter int unsigned AW   = DefAw,
  parameter int unsigned DW   = DefDw,
  parameter int unsigned LW   = DefLw
) (
  input logic                   clk,
  input logic                   reset_n,
  sprite_fetch_arbiter_if.slave bus
);

  localparam int unsigned IW = id_width(NREQ);

  arb_state_e    state_q, state_d;
  logic [LW-1:0] k_q, k_d;
  logic [AW-1:0] base_q, base_d;
  logic [LW-1:0] len_q, len_d;
  logic [IW-1:0] id_q, id_d;
  logic          rd_valid_q, rd_last_q;
  logic [IW-1:0] rd_id_q;

  logic [NREQ-1:0] gnt, ready_c;
  logic [IW-1:0]   gnt_idx;
  logic [AW-1:0]   gnt_addr;
  logic [LW-1:0]   gnt_len;
  logic            issue, last_beat;

  assign gnt_addr = bus.req_addr[gnt_idx*AW +: AW];
  assign gnt_len  = bus.req_len[gnt_idx*LW +: LW];

`ifndef SPRITE_ARB_FIXED_PRIO_EN
  logic [IW-1:0] ptr_q, ptr_d;

  // Round-robin start index; advances past every granted requester.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
`endif

  sprite_rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_i     (bus.req_valid),
`ifndef SPRITE_ARB_FIXED_PRIO_EN
    .ptr_i     (ptr_q),
`endif
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  // Next-state: grant in idle, issue one address per unfrozen burst cycle.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    base_d    = base_q;
    len_d     = len_q;
    id_d      = id_q;
    ready_c   = '0;
    issue     = 1'b0;
    last_beat = 1'b0;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
    ptr_d     = ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (|bus.req_valid) begin
          ready_c = gnt;
          base_d  = gnt_addr;
          len_d   = gnt_len;
          id_d    = gnt_idx;
          k_d     = '0;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
          ptr_d   = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
`endif
          // A zero-length grant is accepted but never leaves idle.
          if (gnt_len != '0) state_d = StBurst;
        end
      end
      StBurst: begin
        if (!bus.freeze) begin
          issue = 1'b1;
          if (k_q == len_q - 1'b1) begin
            last_beat = 1'b1;
            k_d       = '0;
            state_d   = StIdle;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
    endcase
  end

  // Burst state and the one-cycle read-beat pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      k_q        <= '0;
      base_q     <= '0;
      len_q      <= '0;
      id_q       <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_id_q    <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      base_q     <= base_d;
      len_q      <= len_d;
      id_q       <= id_d;
      rd_valid_q <= issue;
      rd_last_q  <= last_beat;
      rd_id_q    <= id_q;
    end
  end

  // Grant is combinational, so it is forced low while reset is asserted.
  assign bus.req_ready      = reset_n ? ready_c : '0;
  assign bus.mem_chipselect = issue;
  // Address wraps naturally at AW bits.
  assign bus.mem_address    = (state_q == StBurst) ? base_q + AW'(k_q) : '0;
  assign bus.busy           = (state_q == StBurst);
  assign bus.rd_valid       = rd_valid_q;
  assign bus.rd_last        = rd_last_q;
  assign bus.rd_id          = rd_id_q;
  assign bus.rd_data        = rd_valid_q ? bus.mem_readdata : {DW{1'b0}};

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Self-checking bench for sprite_fetch_arbiter: directed scenarios plus random traffic,
// all checked every cycle against a transaction-level reference model.
// Build option: SPRITE_ARB_FIXED_PRIO_EN swaps the round-robin scenarios for a fixed-priority one.
module tb_sprite_fetch_arbiter;
  import sprite_arb_pkg::*;

  localparam int N  = DefNreq;
  localparam int AW = DefAw;
  localparam int LW = DefLw;

  logic clk;
  logic reset_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sprite_fetch_arbiter_if bus ();

  sprite_fetch_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Sprite RAM contents: unique per address.
  function automatic logic [15:0] ramf(input logic [10:0] a);
    return {5'b10110, a};
  endfunction

  always @(posedge clk) if (bus.mem_chipselect) bus.mem_readdata <= ramf(bus.mem_address);

  typedef struct {
    logic [N-1:0] rdy;
    logic         cs;
    logic [10:0]  addr;
    logic         rv;
    logic         last;
    logic         busy;
  } smp_t;

  smp_t log_q[$];
  int   n_chk, n_err;
  bit   rearm;

  // Reference model: remaining beats of the current burst and next search start.
  int m_rem, m_k, m_base, m_len, m_id, m_next;
  bit cur_rv, cur_last;
  int cur_addr, cur_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v);
`ifdef SPRITE_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int i = 0; i < N; i++) if (v[(m_next + i) % N]) return (m_next + i) % N;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_rem = 0; m_k = 0; m_base = 0; m_len = 0; m_id = 0; m_next = 0;
    cur_rv = 0; cur_last = 0; cur_addr = 0; cur_id = 0;
  endtask

  task automatic set_req(input int i, input int a, input int l);
    bus.req_addr[i*AW +: AW] = AW'(a);
    bus.req_len[i*LW +: LW]  = LW'(l);
    bus.req_valid[i]         = 1'b1;
  endtask

  // One cycle: predict, compare at the falling edge, then let requesters drop on grant.
  task automatic tick();
    logic [N-1:0] er, seen;
    bit ecs, eb, nrv, nlast;
    int ea, g, l;
    @(negedge clk);
    er = '0; ecs = 0; ea = 0; nrv = 0; nlast = 0;
    eb = (m_rem != 0);
    if (m_rem == 0) begin
      if (bus.req_valid != '0) begin
        g = pick(bus.req_valid);
        er[g] = 1'b1;
        m_next = (g + 1) % N;
        l = int'(bus.req_len[g*LW +: LW]);
        if (l > 0) begin
          m_rem = l; m_k = 0; m_len = l; m_id = g;
          m_base = int'(bus.req_addr[g*AW +: AW]);
        end
      end
    end else if (!bus.freeze) begin
      ecs = 1; ea = (m_base + m_k) % 2048; nrv = 1; nlast = (m_k == m_len - 1);
      m_k++; m_rem--;
    end
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    chk("chipselect", 32'(bus.mem_chipselect), 32'(ecs));
    chk("busy", 32'(bus.busy), 32'(eb));
    chk("rd_valid", 32'(bus.rd_valid), 32'(cur_rv));
    chk("rd_last", 32'(bus.rd_last), 32'(cur_last));
    if (ecs) chk("mem_address", 32'(bus.mem_address), ea);
    if (cur_rv) begin
      chk("rd_data", 32'(bus.rd_data), 32'(ramf(11'(cur_addr))));
      chk("rd_id", 32'(bus.rd_id), cur_id);
    end
    seen = bus.req_ready;
    log_q.push_back('{bus.req_ready, bus.mem_chipselect, bus.mem_address, bus.rd_valid,
                      bus.rd_last, bus.busy});
    cur_rv = nrv; cur_addr = ea; cur_last = nlast; cur_id = m_id;
    @(posedge clk);
    #1;
    if (!rearm) bus.req_valid = bus.req_valid & ~seen;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.req_valid = '0; bus.req_addr = '0; bus.req_len = '0; bus.freeze = 1'b0;
    rearm = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 0);
    chk({tag, "_cs"}, 32'(bus.mem_chipselect), 0);
    chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 0);
    chk({tag, "_rd_last"}, 32'(bus.rd_last), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_mem_address"}, 32'(bus.mem_address), 0);
    chk({tag, "_rd_data"}, 32'(bus.rd_data), 0);
    chk({tag, "_rd_id"}, 32'(bus.rd_id), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int gc[$];
    int gid[$];
    int cnt0, cnt3, nrv;
    n_chk = 0; n_err = 0;

    // Reset state, with all requesters asserting while reset is held.
    reset_n = 1'b0; bus.freeze = 1'b0; rearm = 0;
    bus.req_addr = '0; bus.req_len = '0; bus.req_valid = '1;
    #3;
    chk_outputs_zero("rst");
    do_reset();

    // Req1, addr 0x010, len 3.
    log_q.delete();
    set_req(1, 'h010, 3);
    run(7);
    chk("s1_grant", 32'(log_q[0].rdy), 32'h2);
    for (int k = 0; k < 3; k++) begin
      chk("s1_cs", 32'(log_q[1+k].cs), 1);
      chk("s1_addr", 32'(log_q[1+k].addr), 'h010 + k);
    end
    for (int c = 2; c <= 4; c++) begin
      chk("s1_rv", 32'(log_q[c].rv), 1);
      chk("s1_last", 32'(log_q[c].last), (c == 4) ? 1 : 0);
    end
    chk("s1_rv_after", 32'(log_q[5].rv), 0);
    chk("s1_busy_g3", 32'(log_q[3].busy), 1);
    chk("s1_busy_g4", 32'(log_q[4].busy), 0);

    // Address wrap at the top of sprite RAM.
    log_q.delete();
    set_req(2, 'h7FE, 4);
    run(7);
    chk("s3_a0", 32'(log_q[1].addr), 'h7FE);
    chk("s3_a1", 32'(log_q[2].addr), 'h7FF);
    chk("s3_a2", 32'(log_q[3].addr), 'h000);
    chk("s3_a3", 32'(log_q[4].addr), 'h001);

    // Freeze for two cycles in the middle of a 4-beat burst.
    log_q.delete();
    set_req(0, 'h123, 4);
    run(3);
    bus.freeze = 1'b1;
    run(2);
    bus.freeze = 1'b0;
    run(5);
    chk("s4_cs_pattern", {26'd0, log_q[1].cs, log_q[2].cs, log_q[3].cs, log_q[4].cs,
                          log_q[5].cs, log_q[6].cs}, 32'b110011);
    chk("s4_addr_resume", 32'(log_q[5].addr), 'h125);
    nrv = 0;
    foreach (log_q[i]) nrv += int'(log_q[i].rv);
    chk("s4_beats", nrv, 4);

`ifndef SPRITE_ARB_FIXED_PRIO_EN
    // All four requesting after reset, len 2 each.
    do_reset();
    rearm = 1;
    for (int i = 0; i < N; i++) set_req(i, 'h100 * i + 'h40, 2);
    log_q.delete();
    run(12);
    rearm = 0;
    bus.req_valid = 4'b0001;
    run(6);
    gc.delete(); gid.delete();
    foreach (log_q[i]) if (log_q[i].rdy != '0) begin
      gc.push_back(i);
      gid.push_back($clog2(int'(log_q[i].rdy)));
    end
    chk("s2_ngrants", gc.size(), 5);
    for (int j = 0; j < 5 && j < gc.size(); j++) begin
      chk("s2_order", gid[j], j % N);
      chk("s2_spacing", gc[j] - gc[0], 3 * j);
    end

    // Zero-length grant from req2 still advances the pointer.
    log_q.delete();
    set_req(2, 'h300, 0);
    run(2);
    chk("s5_grant", 32'(log_q[0].rdy), 32'h4);
    chk("s5_single", 32'(log_q[1].rdy), 0);
    chk("s5_no_rv", 32'(log_q[1].rv), 0);
    chk("s5_no_busy", 32'(log_q[1].busy), 0);
    for (int i = 0; i < N; i++) set_req(i, 'h310 + i, 1);
    run(10);
    chk("s5_next_req3", 32'(log_q[2].rdy), 32'h8);
    chk("s5_then_req0", 32'(log_q[4].rdy), 32'h1);
`else
    // Fixed priority: req0 and req3 both held.
    do_reset();
    rearm = 1;
    set_req(0, 'h050, 1);
    set_req(3, 'h350, 1);
    log_q.delete();
    run(12);
    rearm = 0;
    bus.req_valid = '0;
    run(3);
    cnt0 = 0; cnt3 = 0;
    foreach (log_q[i]) begin
      cnt0 += int'(log_q[i].rdy[0]);
      cnt3 += int'(log_q[i].rdy[3]);
    end
    chk("fp_req0_grants", cnt0, 6);
    chk("fp_req3_grants", cnt3, 0);
`endif

    // Reset during beat 2 of an 8-beat burst from req1.
    log_q.delete();
    set_req(1, 'h200, 8);
    run(3);
    #1;
    chk("s6_pre_cs", 32'(bus.mem_chipselect), 1);
    chk("s6_pre_rv", 32'(bus.rd_valid), 1);
    reset_n = 1'b0;
    bus.req_valid = '1;
    #1;
    chk_outputs_zero("s6");
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    log_q.delete();
    for (int i = 0; i < N; i++) set_req(i, 'h400 + 4 * i, 1);
    run(10);
    chk("s6_first_req0", 32'(log_q[0].rdy), 32'h1);
    nrv = 0;
    foreach (log_q[i]) nrv += int'(log_q[i].rv);
    chk("s6_beats", nrv, 4);

    // Random traffic with freeze and withdrawals.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 3) == 0)
          set_req(i, int'($urandom_range(0, 2047)),
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31))
                                              : int'($urandom_range(0, 4)));
        else if (bus.req_valid[i] && $urandom_range(0, 40) == 0)
          bus.req_valid[i] = 1'b0;
      end
      bus.freeze = ($urandom_range(0, 3) == 0);
      tick();
    end
    bus.req_valid = '0;
    bus.freeze = 1'b0;
    run(40);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sprite_fetch_arbiter.md
SPRITE_FETCH_ARBITER -- requirements
Module: sprite_fetch_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NREQ, 4, number of sprite requesters
- AW, 11, sprite RAM read-port address width (2048 x 16-bit words)
- DW, 16, sprite RAM read-port data width
- LW, 5, burst length field width
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. Clock and reset come first.
- clk, in, 1, single clock for all logic
- reset_n, in, 1, asynchronous active-low reset
- req_valid, in, NREQ, per-requester fetch request
- req_addr, in, NREQ*AW, per-requester base word address; requester i occupies slice i
- req_len, in, NREQ*LW, per-requester burst length in words (0..2^LW-1)
- req_ready, out, NREQ, one-hot grant/accept pulse
- freeze, in, 1, suspends address issue
- mem_address, out, AW, RAM read-port address
- mem_chipselect, out, 1, high on an address-issue cycle
- mem_readdata, in, DW, RAM read data; valid the cycle after the address is issued
- rd_valid, out, 1, read beat valid
- rd_data, out, DW, read beat data
- rd_id, out, clog2(NREQ), requester owning the beat
- rd_last, out, 1, final beat of the burst
- busy, out, 1, high while a burst is in progress

Function
REQ-003 The state machine SHALL have two states, IDLE and BURST.
REQ-004 In IDLE, when any req_valid bit is set, the block SHALL grant exactly one requester: pulse req_ready[g] for one cycle and latch its base address, length and id.
REQ-005 After a grant with len>0, the next state SHALL be BURST. After a grant with len=0, the block SHALL stay in IDLE, issue no beats and pulse no rd_valid.
REQ-006 In BURST, each cycle with freeze=0 SHALL issue one address: mem_address=base+k, mem_chipselect=1, then k increments.
REQ-007 Address arithmetic SHALL be modulo 2^AW, so base+k wraps from 2047 to 0.
REQ-008 In BURST, a cycle with freeze=1 SHALL issue nothing: mem_chipselect=0 and k holds.
REQ-009 rd_valid SHALL assert exactly one cycle after each issue cycle, with rd_data=mem_readdata, rd_id equal to the latched id, and rd_last=1 on beat len-1.
REQ-010 The cycle that issues beat len-1 SHALL transition the state to IDLE. Grant-to-first-rd_valid latency SHALL be 2 cycles with freeze=0. Per-request occupancy SHALL be len+1 cycles.
REQ-011 freeze SHALL NOT block a grant in IDLE, and SHALL NOT suppress the rd_valid for an address issued in the previous cycle.
REQ-012 Arbitration SHALL be round-robin. The search starts at (last granted + 1) mod NREQ. The pointer updates on every grant, including len=0 grants.
REQ-013 A requester SHALL hold req_valid, req_addr and req_len stable until its req_ready. Deasserting req_valid before grant withdraws the request without side effects.
REQ-014 New requests arriving during BURST SHALL wait; they SHALL be arbitrated in the first IDLE cycle.
REQ-015 busy SHALL equal (state==BURST).

Reset
REQ-016 While reset_n=0, asynchronously: state=IDLE, rr pointer=0, k=0, and req_ready, mem_chipselect, rd_valid, rd_last, busy, mem_address, rd_data and rd_id all 0.
REQ-017 Reset during BURST SHALL abandon the burst. No rd_valid SHALL follow the release of reset.

Configuration
REQ-018 With SPRITE_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority: the lowest active index wins and the rr pointer is not implemented. Without it, REQ-012 round-robin applies.

Structure
REQ-019 Package sprite_arb_pkg SHALL hold the state enum and the default parameter constants (AW, DW, LW, NREQ).
REQ-020 Grant selection SHALL be a sub-module, sprite_rr_arbiter: combinational one-hot grant from request vector and pointer, with the macro selecting fixed priority.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Req1 addr=0x010, len=3, no contention -> req_ready=0010 at cycle G; addresses 0x010, 0x011, 0x012 at G+1..G+3; rd_valid at G+2..G+4; rd_last at G+4; rd_id=1.
- All four requesting, len=2 each, after reset -> grant order 0,1,2,3,0; each grant 3 cycles apart.
- Addr=0x7FE, len=4 -> addresses 0x7FE, 0x7FF, 0x000, 0x001.
- freeze=1 for 2 cycles mid-burst of len=4 -> chipselect gaps of 2 cycles; exactly 4 rd_valid beats, data in order.
- len=0 request from req2 -> one req_ready pulse, no rd_valid, pointer advances (next grant goes to req3 when all are pending).
- reset_n low during beat 2 of len=8 -> all outputs 0 immediately; no rd_valid after release; next grant goes to req0.
- With SPRITE_ARB_FIXED_PRIO_EN defined, req0 and req3 both held -> req0 is always granted and req3 never is.
